// File: rtl/cpu_io_pkg.sv
// Shared constants and helpers for the CPU I/O bridge.
// The four I/O registers sit in the top four byte addresses. Each register
// is named by its offset below TOP = 2^ADDR_WIDTH.
package cpu_io_pkg;

    // Register offsets below the top of the address space
    localparam int OFF_TXDATA = 4;
    localparam int OFF_RXDATA = 3;
    localparam int OFF_STATUS = 2;
    localparam int OFF_CTRL   = 1;

    // STATUS register bit positions
    localparam int ST_RX_NONEMPTY = 0;
    localparam int ST_TX_FULL     = 1;
    localparam int ST_TX_EMPTY    = 2;
    localparam int ST_RX_OVF      = 3;
    localparam int ST_TX_OVF      = 4;

    // CTRL register bit positions
    localparam int CTRL_HALT_BIT = 0;

    typedef enum logic [2:0] {
        IO_NONE,
        IO_TXDATA,
        IO_RXDATA,
        IO_STATUS,
        IO_CTRL
    } io_reg_e;

    // Maps an address to its I/O register. in_window is high when the upper
    // address bits are all ones. low holds the two least-significant address
    // bits. TOP-k has low bits equal to (4-k) mod 4.
    function automatic io_reg_e decode_io(input logic in_window, input logic [1:0] low);
        io_reg_e sel;
        sel = IO_NONE;
        if (in_window) begin
            if (low == 2'(4 - OFF_TXDATA))
                sel = IO_TXDATA;
            else if (low == 2'(4 - OFF_RXDATA))
                sel = IO_RXDATA;
            else if (low == 2'(4 - OFF_STATUS))
                sel = IO_STATUS;
            else
                sel = IO_CTRL;
        end
        return sel;
    endfunction

endpackage

// File: rtl/cpu_io_bridge_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers. DEPTH must be a power of two and
// must be at least 2.
// A pop on an empty FIFO is ignored. A push on a full FIFO is accepted only
// when a pop happens on the same clock edge. When the FIFO is empty, dout
// reads 0.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Advance the pointers on accepted pushes and effective pops
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)
                rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage is not reset; the pointers make stale entries unreachable
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/cpu_io_bridge.sv
// CPU memory-port bridge. It routes CPU accesses to block RAM or to four
// I/O registers at the top of the address space:
//   TXDATA at TOP-4
//   RXDATA at TOP-3
//   STATUS at TOP-2
//   CTRL   at TOP-1
// Read data for both RAM and I/O comes back one cycle after the address.
// Optional feature macro: CPU_IO_RX_EN builds the RX FIFO, the RXDATA
// register and the rx_ovf flag. Without it, RX reads as 0 and rx_ready is
// held low.
module cpu_io_bridge
    import cpu_io_pkg::*;
#(
    parameter int ADDR_WIDTH = 9,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] mem_raddr,
    input  logic [ADDR_WIDTH-1:0] mem_waddr,
    input  logic [7:0]            mem_wdata,
    input  logic                  mem_write,
    output logic [7:0]            mem_rdata,
    output logic                  mem_ready,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    input  logic [7:0]            ram_rdata,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [7:0]            ram_wdata,
    output logic                  ram_we,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  cpu_halt
);

    io_reg_e    raddr_reg;
    io_reg_e    waddr_reg;
    logic       wr_txdata;
    logic       wr_status;
    logic       wr_ctrl;

    logic       tx_full;
    logic       tx_empty;
    logic       tx_pop;
    logic       tx_drop;
    logic       tx_ovf;

    logic       rx_empty;
    logic       rx_access;
    logic       rx_hold;
    logic       rx_ovf;
    logic [7:0] rx_head;

    logic       io_sel_q;
    logic [7:0] io_data_q;
    logic [7:0] io_rd_value;
    logic       io_rd_load;
    logic [7:0] status_value;

    assign raddr_reg = decode_io(&mem_raddr[ADDR_WIDTH-1:2], mem_raddr[1:0]);
    assign waddr_reg = decode_io(&mem_waddr[ADDR_WIDTH-1:2], mem_waddr[1:0]);

    assign wr_txdata = mem_write && (waddr_reg == IO_TXDATA);
    assign wr_status = mem_write && (waddr_reg == IO_STATUS);
    assign wr_ctrl   = mem_write && (waddr_reg == IO_CTRL);

    assign ram_raddr = mem_raddr;
    assign ram_waddr = mem_waddr;
    assign ram_wdata = mem_wdata;
    assign ram_we    = mem_write && (waddr_reg == IO_NONE);

    // TX side: the CPU pushes bytes, and the UART drains the FIFO head
    assign tx_valid = !tx_empty;
    assign tx_pop   = tx_valid && tx_ready;
    assign tx_drop  = wr_txdata && tx_full && !tx_pop;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_txdata),
        .pop   (tx_pop),
        .din   (mem_wdata),
        .dout  (tx_data),
        .full  (tx_full),
        .empty (tx_empty)
    );

`ifdef CPU_IO_RX_EN
    logic [ADDR_WIDTH-1:0] prev_raddr;
    logic                  rx_full;
    logic                  rx_drop;
    io_reg_e               prev_reg;

    assign prev_reg  = decode_io(&prev_raddr[ADDR_WIDTH-1:2], prev_raddr[1:0]);
    assign rx_access = (raddr_reg == IO_RXDATA) && (prev_reg != IO_RXDATA);
    assign rx_hold   = (raddr_reg == IO_RXDATA) && !rx_access;
    assign rx_drop   = rx_valid && rx_full && !rx_access;
    assign rx_ready  = !rx_full;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rx_valid),
        .pop   (rx_access),
        .din   (rx_data),
        .dout  (rx_head),
        .full  (rx_full),
        .empty (rx_empty)
    );

    // Track the last read address so a held RXDATA address pops only once, and keep the sticky RX overflow flag
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_raddr <= '0;
            rx_ovf     <= 1'b0;
        end else begin
            prev_raddr <= mem_raddr;
            if (rx_drop)
                rx_ovf <= 1'b1;
            else if (wr_status && mem_wdata[ST_RX_OVF])
                rx_ovf <= 1'b0;
        end
    end
`else
    logic unused_rx;

    assign unused_rx = ^{rx_data, rx_valid};
    assign rx_access = 1'b0;
    assign rx_hold   = 1'b0;
    assign rx_empty  = 1'b1;
    assign rx_head   = 8'h00;
    assign rx_ovf    = 1'b0;
    assign rx_ready  = 1'b0;
`endif

    // Assemble the STATUS read value from live FIFO state and the sticky flags
    always_comb begin
        status_value                 = '0;
        status_value[ST_RX_NONEMPTY] = !rx_empty;
        status_value[ST_TX_FULL]     = tx_full;
        status_value[ST_TX_EMPTY]    = tx_empty;
        status_value[ST_RX_OVF]      = rx_ovf;
        status_value[ST_TX_OVF]      = tx_ovf;
    end

    // Select the I/O read value; a held RXDATA address keeps the byte captured on the first access
    always_comb begin
        io_rd_value = '0;
        io_rd_load  = 1'b1;
        case (raddr_reg)
            IO_RXDATA: begin
                io_rd_value = rx_access ? rx_head : 8'h00;
                io_rd_load  = !rx_hold;
            end
            IO_STATUS: io_rd_value = status_value;
            IO_CTRL:   io_rd_value[CTRL_HALT_BIT] = cpu_halt;
            default:   io_rd_value = '0;
        endcase
    end

    // Register the read path, the TX overflow flag, the halt bit and the ready flag
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_ready <= 1'b0;
            io_sel_q  <= 1'b0;
            io_data_q <= '0;
            tx_ovf    <= 1'b0;
            cpu_halt  <= 1'b0;
        end else begin
            mem_ready <= 1'b1;
            io_sel_q  <= (raddr_reg != IO_NONE);
            if (io_rd_load)
                io_data_q <= io_rd_value;
            if (tx_drop)
                tx_ovf <= 1'b1;
            else if (wr_status && mem_wdata[ST_TX_OVF])
                tx_ovf <= 1'b0;
            if (wr_ctrl && mem_wdata[CTRL_HALT_BIT])
                cpu_halt <= 1'b1;
        end
    end

    // An access in flight across reset reads back 0 until the bridge is ready again
    assign mem_rdata = !mem_ready ? 8'h00 : (io_sel_q ? io_data_q : ram_rdata);

endmodule

// File: doc/cpu_io_bridge.md
Name: cpu_io_bridge

Overview:
- Sits directly downstream of the CPU's byte-wide memory port.
- Routes each CPU access either to the block RAM or to four memory-mapped I/O registers at the top of the address space.
- The I/O registers provide a TX FIFO and an RX FIFO towards the UART, a sticky status register, and a CPU halt control bit.
- RAM and I/O read data both reach the CPU with 1-cycle registered latency, which fits the CPU's two-cycle read window (address-setup cycle plus wait cycle).

Parameters:
- ADDR_WIDTH, 9, CPU/RAM byte address width.
- FIFO_DEPTH, 8, entries per FIFO; must be a power of 2 and at least 2.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- mem_raddr  in  ADDR_WIDTH  CPU read address, held stable until the CPU changes it
- mem_waddr  in  ADDR_WIDTH  CPU write address
- mem_wdata  in  8  CPU write data
- mem_write  in  1  CPU single-cycle write strobe
- mem_rdata  out  8  read data to CPU
- mem_ready  out  1  bridge ready
- ram_raddr  out  ADDR_WIDTH  RAM read address (combinational copy of mem_raddr)
- ram_rdata  in  8  RAM read data, valid 1 cycle after ram_raddr
- ram_waddr  out  ADDR_WIDTH  RAM write address (copy of mem_waddr)
- ram_wdata  out  8  RAM write data (copy of mem_wdata)
- ram_we  out  1  RAM write enable
- tx_data  out  8  byte to UART transmitter
- tx_valid  out  1  TX FIFO not empty
- tx_ready  in  1  UART accepts tx_data when tx_valid and tx_ready are both high
- rx_data  in  8  byte from UART receiver
- rx_valid  in  1  rx_data valid; single-cycle push
- rx_ready  out  1  RX FIFO not full
- cpu_halt  out  1  CTRL bit0; drives CPU halt input

Behaviour:
- Address map, with TOP = 2^ADDR_WIDTH:
  - TOP-4: TXDATA
  - TOP-3: RXDATA
  - TOP-2: STATUS
  - TOP-1: CTRL
  - All other addresses are RAM.
- Writes:
  - Write to a RAM address: ram_we = mem_write, same cycle, combinational.
  - Write to an I/O address: ram_we = 0.
- Reads:
  - Read select registered: io_sel_q <= (mem_raddr >= TOP-4); io_data_q <= I/O read value.
  - mem_rdata = io_sel_q ? io_data_q : ram_rdata.
  - Latency 1 cycle, independent of target.
- TXDATA:
  - Write pushes mem_wdata when TX FIFO is not full.
  - Write when full drops the byte and sets tx_ovf.
  - Reads return 0.
- RXDATA:
  - Read access = cycle where mem_raddr == RXDATA and the previous cycle's mem_raddr != RXDATA.
  - On a read access: io_data_q <= FIFO head, and the FIFO pops in the same edge, so the CPU sees the pre-pop head.
  - Read access when empty returns 0 and performs no pop.
  - Holding mem_raddr at RXDATA causes no further pops.
  - The previous-address register resets to 0.
- STATUS read bits:
  - [0] rx_nonempty
  - [1] tx_full
  - [2] tx_empty
  - [3] rx_ovf
  - [4] tx_ovf
  - [7:5] = 0
- STATUS write: write-1-to-clear for bits [4:3]; other bits ignored.
  - If clear and set occur in the same cycle, set wins.
- CTRL:
  - bit0 = cpu_halt, readable and writable; bits [7:1] read 0.
  - Once the CPU halts, only reset clears cpu_halt.
- RX push:
  - rx_valid && !full pushes rx_data.
  - rx_valid && full drops the byte and sets rx_ovf.
  - rx_ready = !rx_full.
- FIFO rules (both FIFOs):
  - Simultaneous push and pop on a full FIFO: pop occurs, and the push is also accepted.
  - Simultaneous push and pop on an empty FIFO: push only; the pop reads 0 / is ignored.
  - Pointers have ADDR bits plus 1 wrap bit; full/empty come from pointer compare.
  - Count is never out of [0, FIFO_DEPTH].
- TX drain: pop when tx_valid && tx_ready; tx_data = head, combinational from the FIFO.
- Reset values:
  - mem_rdata source registers = 0; mem_ready = 0.
  - tx_valid = 0, rx_ready = 1, cpu_halt = 0.
  - Both FIFOs empty; tx_ovf = rx_ovf = 0.
  - mem_ready rises 1 cycle after reset deasserts and stays high.
- Reset mid-operation: FIFO contents are discarded; an in-flight CPU access returns 0.

Optional Feature:
- CPU_IO_RX_EN defined: RX FIFO, RXDATA register and rx_ovf are present as described above.
- CPU_IO_RX_EN undefined:
  - RX FIFO, RXDATA register and rx_ovf are not built.
  - RXDATA reads return 0; STATUS[0] and STATUS[3] read 0.
  - rx_ready is held 0; rx_data and rx_valid are ignored.

Decomposition:
- Package cpu_io_pkg holds:
  - I/O offset constants (OFF_TXDATA = 4, OFF_RXDATA = 3, OFF_STATUS = 2, OFF_CTRL = 1, each subtracted from TOP).
  - STATUS bit indices.
  - CTRL_HALT_BIT = 0.
- Sub-module sync_fifo (WIDTH, DEPTH; push, pop, din, dout, full, empty), instantiated twice.

Test Plan:
- RAM path: write 0x5A to address 0x010, then read 0x010 -> mem_rdata = 0x5A one cycle after raddr is applied; ram_we pulses exactly once.
- TX path: write 0x41, 0x42, 0x43 to TXDATA with tx_ready = 0; STATUS reads 0x00; raise tx_ready -> tx_data presents 0x41, 0x42, 0x43 on consecutive cycles; STATUS then reads 0x04.
- TX overflow: push 9 bytes with tx_ready = 0 and FIFO_DEPTH = 8 -> STATUS reads 0x12. Write 0x10 to STATUS -> STATUS reads 0x02; the 9th byte never appears on tx_data.
- RX path: pulse rx_valid with 0x31 then 0x32; read RXDATA with raddr held for 3 cycles -> 0x31 with a single pop. Change raddr away and back -> 0x32. Third read -> 0x00, STATUS[0] = 0.
- RX simultaneous events: with the FIFO full, rx_valid coincides with a CPU RXDATA read access -> pop returns the oldest byte, the new byte is accepted, rx_ovf stays 0.
- Control and reset: write 0x01 to CTRL -> cpu_halt = 1 and CTRL reads 0x01. Assert reset with bytes queued -> tx_valid = 0, cpu_halt = 0, STATUS = 0x04 after reset; mem_ready low during reset, high 1 cycle after.
